// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, default sample width and address-width helper
// for the ADC capture block.
package adc_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  // Address width needed to index a buffer of the given depth (at least 1 bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// adc_capture_ram: simple dual-port record buffer, one write port and one read
// port with a registered read (1-cycle latency). The array itself is not reset
// so it maps onto block RAM; only the read register is cleared.
module adc_capture_ram
  import adc_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds the last word until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC sample-clock divider, decimating level-crossing trigger and
// fixed-length record capture with a sequential read-out port.
// Optional feature macro: ADC_TRIG_TIMEOUT_EN -- when defined, a record is
// force-triggered after TIMEOUT mclk cycles in ARMED and timed_out is raised.
module adc_capture
  import adc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  input  logic              start,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [7:0]        decim,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              timed_out
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int DIV_W  = addr_w(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  // Elaboration-time parameter sanity checks.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("adc_capture: DEPTH must be a power of two >= 4");
  end
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
    $error("adc_capture: CLK_DIV must be even and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("adc_capture: TIMEOUT must be >= 1");
  end

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              adc_clk_q, adc_clk_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic              smp_vld_q, smp_vld_d;
  logic [7:0]        dec_cnt_q, dec_cnt_d;
  logic [7:0]        decim_cfg_q, decim_cfg_d;
  logic [DATA_W-1:0] lvl_cfg_q, lvl_cfg_d;
  logic              edge_cfg_q, edge_cfg_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;

  logic              strobe;
  logic              accept;
  logic              trig_hit;
  logic              force_trig;
  logic              we, re;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] wr_nxt;

  // Free-running divider, registered sample clock and sample strobe.
  always_comb begin
    strobe    = (div_cnt_q == DIV_LAST);
    div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
    adc_clk_d = (div_cnt_q < DIV_HALF);
    smp_d     = strobe ? adc_data : smp_q;
    smp_vld_d = strobe;
  end

  // Trigger detection against the previous accepted sample.
  always_comb begin
    accept   = smp_vld_q && (dec_cnt_q == 8'd0);
    trig_hit = 1'b0;
    if (prev_vld_q) begin
      if (edge_cfg_q) trig_hit = (prev_q >= lvl_cfg_q) && (smp_q <  lvl_cfg_q);
      else            trig_hit = (prev_q <  lvl_cfg_q) && (smp_q >= lvl_cfg_q);
    end
  end

  // Capture FSM next state: start aborts from any state and wins over
  // a same-cycle trigger, final write or read request.
  always_comb begin
    state_d     = state_q;
    dec_cnt_d   = dec_cnt_q;
    decim_cfg_d = decim_cfg_q;
    lvl_cfg_d   = lvl_cfg_q;
    edge_cfg_d  = edge_cfg_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_nxt      = wr_ptr_q + 1'b1;
    we          = 1'b0;
    waddr       = wr_nxt;
    re          = 1'b0;

    if (smp_vld_q) dec_cnt_d = (dec_cnt_q == decim_cfg_q) ? 8'd0 : dec_cnt_q + 1'b1;

    if (start) begin
      state_d     = ARMED;
      dec_cnt_d   = 8'd0;
      prev_vld_d  = 1'b0;
      decim_cfg_d = decim;
      lvl_cfg_d   = trig_level;
      edge_cfg_d  = trig_edge;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (accept) begin
            prev_d     = smp_q;
            prev_vld_d = 1'b1;
            if (trig_hit || force_trig) begin
              we       = 1'b1;
              waddr    = '0;
              wr_ptr_d = '0;
              state_d  = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            we       = 1'b1;
            wr_ptr_d = wr_nxt;
            if (wr_nxt == ADDR_LAST) begin
              state_d  = DONE;
              rd_ptr_d = '0;
            end
          end
        end
        DONE: begin
          if (rd_en) begin
            re       = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      endcase
    end

    busy_d     = (state_d == ARMED) || (state_d == CAPTURE);
    done_d     = (state_d == DONE);
    rd_valid_d = re;
  end

  // Control state: divider, decimation, configuration, FSM and registered outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      adc_clk_q   <= 1'b0;
      smp_vld_q   <= 1'b0;
      dec_cnt_q   <= 8'd0;
      decim_cfg_q <= 8'd0;
      lvl_cfg_q   <= '0;
      edge_cfg_q  <= 1'b0;
      prev_vld_q  <= 1'b0;
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      adc_clk_q   <= adc_clk_d;
      smp_vld_q   <= smp_vld_d;
      dec_cnt_q   <= dec_cnt_d;
      decim_cfg_q <= decim_cfg_d;
      lvl_cfg_q   <= lvl_cfg_d;
      edge_cfg_q  <= edge_cfg_d;
      prev_vld_q  <= prev_vld_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Sample and trigger-history data; qualified by smp_vld_q / prev_vld_q.
  always_ff @(posedge mclk) begin
    smp_q  <= smp_d;
    prev_q <= prev_d;
  end

`ifdef ADC_TRIG_TIMEOUT_EN
  localparam int TO_W = addr_w(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timed_out_q, timed_out_d;

  assign force_trig = (to_cnt_q == TO_LIM);

  // Count ARMED cycles; once expired the next accepted sample is forced in.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    if (start) begin
      to_cnt_d    = '0;
      timed_out_d = 1'b0;
    end else if (state_q == ARMED) begin
      if (accept && force_trig && !trig_hit) timed_out_d = 1'b1;
      if (!force_trig) to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout counter and flag registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign force_trig = 1'b0;
  assign timed_out  = 1'b0;
`endif

  adc_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (mclk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (smp_q),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign adc_clk  = adc_clk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture. The bench models the ADC by
// moving adc_data one step after each falling edge of adc_clk.
module tb_adc_capture;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 256;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 100;

  typedef enum {HOLD, UP, DN} ramp_t;

  logic              mclk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_clk;
  logic              start = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_edge = 1'b0;
  logic [7:0]        decim = '0;
  logic              busy, done;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              timed_out;

  ramp_t ramp_mode = HOLD;
  logic  clk_prev = 1'b0;
  logic  fell = 1'b0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;

  always #10 mclk = ~mclk;

  adc_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CLK_DIV(CLK_DIV),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .adc_data  (adc_data),
    .adc_clk   (adc_clk),
    .start     (start),
    .trig_level(trig_level),
    .trig_edge (trig_edge),
    .decim     (decim),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .timed_out (timed_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mclk cycle; sample #1 after the edge and step the ADC model on adc_clk fall.
  task automatic tick();
    @(posedge mclk);
    #1;
    fell = clk_prev && !adc_clk;
    if (fell) begin
      if (ramp_mode == UP)      adc_data = adc_data + 8'd1;
      else if (ramp_mode == DN) adc_data = adc_data - 8'd1;
    end
    clk_prev = adc_clk;
  endtask

  // Start a capture aligned so that v0 is the first sample seen after arming.
  task automatic arm(input logic [7:0] v0, input ramp_t m, input logic [7:0] lvl,
                     input logic edg, input logic [7:0] dec, input logic rden);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fell && n < 8);
    adc_data   = v0;
    ramp_mode  = m;
    trig_level = lvl;
    trig_edge  = edg;
    decim      = dec;
    start      = 1'b1;
    rd_en      = rden;
    tick();
    start = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic read_words(input int first, input int stride, input int count, input string tag);
    for (int i = 0; i < count; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, " valid"}, rd_valid, 1);
      chk($sformatf("%s word%0d", tag, i), rd_data, (first + stride * (i % DEPTH)) & 255);
      tick();
      chk({tag, " valid drop"}, rd_valid, 0);
    end
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst adc_clk", adc_clk, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst timed_out", timed_out, 0);
    tick();
    tick();
    rst = 1'b0;

    // Divider pattern 1,1,0,0 from reset release, undisturbed by a start pulse
    trig_level = 8'h80;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 5);
      tick();
      chk($sformatf("clk pattern %0d", k), adc_clk, (((k - 1) % 4) < 2) ? 1 : 0);
    end
    start = 1'b0;
    chk("armed busy", busy, 1);

    // Rising ramp, level 100, decim 0
    arm(8'd90, UP, 8'd100, 1'b0, 8'd0, 1'b0);
    chk("ramp busy", busy, 1);
    chk("ramp timed_out", timed_out, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rd_en outside done", rd_valid, 0);
    repeat (1056) tick();
    chk("ramp done early", done, 0);
    chk("ramp busy early", busy, 1);
    repeat (6) tick();
    chk("ramp done", done, 1);
    chk("ramp busy clear", busy, 0);
    chk("ramp timed_out end", timed_out, 0);
    read_words(100, 1, DEPTH + 2, "ramp");

    // Decimation by 4
    arm(8'd80, UP, 8'd100, 1'b0, 8'd3, 1'b0);
    chk("decim done cleared", done, 0);
    wait_done(4400, "decim done");
    read_words(100, 4, 6, "decim");

    // Falling crossing of 0x80
    arm(8'h8A, DN, 8'h80, 1'b1, 8'd0, 1'b0);
    wait_done(1200, "fall done");
    read_words(8'h7F, -1, 4, "fall");

    // Constant at the falling threshold never triggers
    arm(8'h80, HOLD, 8'h80, 1'b1, 8'd0, 1'b0);
    repeat (60) tick();
    chk("const fall busy", busy, 1);
    chk("const fall done", done, 0);

    // Abort mid-capture and re-arm on a different level
    arm(8'd90, UP, 8'd100, 1'b0, 8'd0, 1'b0);
    repeat (100) tick();
    arm(8'd145, UP, 8'd150, 1'b0, 8'd0, 1'b0);
    chk("abort busy", busy, 1);
    chk("abort done", done, 0);
    repeat (1037) tick();
    chk("abort done early", done, 0);
    repeat (6) tick();
    chk("abort done", done, 1);
    read_words(150, 1, 2, "abort");

    // Start together with rd_en in DONE: read ignored, capture re-armed
    arm(8'd95, UP, 8'd100, 1'b0, 8'd0, 1'b1);
    chk("start+rd_en valid", rd_valid, 0);
    chk("start+rd_en busy", busy, 1);
    chk("start+rd_en done", done, 0);
    repeat (60) tick();
    chk("capture busy", busy, 1);

    // Asynchronous reset mid-capture while adc_clk is high
    for (int n = 0; n < 4 && !adc_clk; n++) tick();
    chk("pre-rst adc_clk", adc_clk, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst adc_clk", adc_clk, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst rd_data", rd_data, 0);
    chk("arst rd_valid", rd_valid, 0);
    chk("arst timed_out", timed_out, 0);
    #5 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("post-rst clk %0d", k), adc_clk, (((k - 1) % 4) < 2) ? 1 : 0);
    end
    chk("post-rst busy", busy, 0);
    chk("post-rst done", done, 0);

    // Constant input at a rising threshold: waits, or times out when enabled
    arm(8'h80, HOLD, 8'h80, 1'b0, 8'd0, 1'b0);
    repeat (99) tick();
    chk("const busy", busy, 1);
    chk("const timed_out early", timed_out, 0);
    repeat (5) tick();
`ifdef ADC_TRIG_TIMEOUT_EN
    chk("timeout flag", timed_out, 1);
    wait_done(1200, "timeout done");
    chk("timeout flag held", timed_out, 1);
    read_words(8'h80, 0, 1, "timeout");
    arm(8'h10, HOLD, 8'h80, 1'b0, 8'd0, 1'b0);
    chk("timeout cleared by start", timed_out, 0);
`else
    chk("no timeout flag", timed_out, 0);
    chk("no timeout busy", busy, 1);
    chk("no timeout done", done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart of the board's 8-bit parallel DAC output path.
- Generates the ADC sample clock and registers the ADC parallel bus.
- Waits for a level-crossing trigger, stores a fixed-length record into an internal buffer, then hands the record to the processor system through a sequential read port.
- Sits beside the DAC driver under the processor system wrapper, clocked by mclk (50 MHz).

Parameters:
- DATA_W, 8: ADC sample width.
- DEPTH, 1024: samples per record; power of two, ≥4.
- CLK_DIV, 4: adc_clk = mclk/CLK_DIV; even, ≥2.
- TIMEOUT, 1000000: mclk cycles in ARMED before forced trigger (optional feature only).

Ports:
- mclk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- adc_data  in  DATA_W  ADC parallel output, valid around adc_clk rising edge.
- adc_clk  out  1  ADC sample clock.
- start  in  1  one-cycle pulse: arm (or re-arm) capture.
- trig_level  in  DATA_W  unsigned trigger threshold.
- trig_edge  in  1  0 = rising crossing, 1 = falling crossing.
- decim  in  8  keep one sample in decim+1.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- rd_en  in  1  pop next stored sample.
- rd_data  out  DATA_W  sample read out.
- rd_valid  out  1  rd_data valid strobe.
- timed_out  out  1  record was force-triggered (optional feature only; else tied 0).

Behaviour:
- Reset values: adc_clk=0, busy=0, done=0, rd_data=0, rd_valid=0, timed_out=0. State IDLE; all counters 0.
- Divider: div_cnt counts 0..CLK_DIV-1 continuously, in every state. adc_clk=1 when div_cnt<CLK_DIV/2, registered.
- Sample strobe: at div_cnt==CLK_DIV-1, adc_data is registered into smp.
- Decimation: dec_cnt counts strobes 0..decim. A sample is "accepted" when dec_cnt==0. decim is sampled at start.
- trig_level and trig_edge are sampled at start.
- IDLE: start → ARMED.
- ARMED:
  - Tracks prev accepted sample. The first accepted sample after arming only loads prev; no trigger is evaluated.
  - Rising edge: trigger when prev<level and cur>=level.
  - Falling edge: trigger when prev>=level and cur<level.
  - On trigger, the triggering sample is written at address 0 and the state moves to CAPTURE.
- CAPTURE: each accepted sample is written at wr_ptr+1. After address DEPTH-1 is written → DONE.
- DONE:
  - rd_ptr resets to 0 on entry.
  - rd_en: rd_data=mem[rd_ptr] with rd_valid high exactly 1 cycle later (latency 1); rd_ptr increments.
  - rd_ptr wraps DEPTH-1 → 0.
  - rd_en outside DONE is ignored (rd_valid stays 0).
- start in any state (including ARMED, CAPTURE, DONE) aborts, clears the decimation and trigger history and done, and → ARMED. start takes priority over a same-cycle trigger or final write.
- rd_en in the same cycle as start is ignored.
- Buffer: single-port-write, single-port-read memory of DEPTH×DATA_W, inferable as block RAM. Contents are not reset.
- rst mid-capture: immediate return to IDLE; partial record discarded.

Optional Feature:
- Macro: ADC_TRIG_TIMEOUT_EN.
- With it:
  - A counter runs in ARMED.
  - After TIMEOUT mclk cycles without a trigger, the next accepted sample is taken as the trigger sample (written at address 0) → CAPTURE, and timed_out is set.
  - timed_out clears on start/rst.
- Without it: ARMED waits indefinitely; timed_out is constant 0 and no counter is built.

Decomposition:
- Shared package adc_pkg:
  - state encoding enum (IDLE, ARMED, CAPTURE, DONE);
  - DATA_W default;
  - ADDR_W = $clog2(DEPTH) helper function.
- One sub-module, adc_capture_ram: simple dual-port synchronous RAM with 1-cycle read latency.
- Divider, trigger and FSM stay in adc_capture.

Test Plan:
- Ramp test: adc_data ramps 0..255 per strobe; CLK_DIV=4, decim=0, trig_level=100, trig_edge=0, start → first word read = 100, next = 101, ..., all DEPTH words sequential mod 256; done high after exactly DEPTH accepted samples.
- Falling trigger: descending ramp, trig_level=0x80, trig_edge=1 → first word = 0x7F. Holding adc_data constant at 0x80 never triggers.
- Decimation: ramp with decim=3 → stored words differ by 4 (e.g. 100,104,108,...).
- Adc_clk timing: adc_clk is 12.5 MHz, 50% duty, with no glitch across start or rst.
- Abort: start pulse mid-CAPTURE → busy stays high, done low, new record begins at the next crossing. rst mid-CAPTURE → all outputs return to reset values the same cycle.
- Readout: DEPTH+2 rd_en pulses in DONE → rd_valid one cycle after each; words DEPTH and DEPTH+1 equal words 0 and 1 (wrap).
- With ADC_TRIG_TIMEOUT_EN, TIMEOUT=100: constant input → capture starts ≤100+CLK_DIV cycles after start, timed_out=1.
